// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/bubble/flush handling, multiply-accumulate
// partial-result feedback to ex, and a saturating bubble counter.
module ex_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_ex,
  input  logic                stall_mem,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_waddr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_we,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  input  logic [1:0]          ex_cnt,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [1:0]          cnt_o,
  output logic [31:0]         bubble_cnt
);

  logic insert_bubble;
  logic [31:0] bubble_nxt;

  // A counted bubble is only the stall_ex-without-stall_mem case; flush bubbles are not counted.
  assign insert_bubble = !flush && stall_ex && !stall_mem;

  always_comb begin
    bubble_nxt = bubble_cnt;
    if (insert_bubble && (bubble_cnt != 32'hFFFF_FFFF))
      bubble_nxt = bubble_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      bubble_cnt <= '0;
    else
      bubble_cnt <= bubble_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_hi      <= '0;
      mem_lo      <= '0;
      mem_whilo   <= 1'b0;
      mem_valid   <= 1'b0;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else if (insert_bubble) begin
      // The multicycle op's partial result survives the bubble so ex can resume it.
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_hi      <= '0;
      mem_lo      <= '0;
      mem_whilo   <= 1'b0;
      mem_valid   <= 1'b0;
      hilo_temp_o <= ex_hilo_temp;
      cnt_o       <= ex_cnt;
    end else if (!stall_mem) begin
      mem_waddr   <= ex_waddr;
      mem_wdata   <= ex_wdata;
      mem_we      <= ex_we;
      mem_hi      <= ex_hi;
      mem_lo      <= ex_lo;
      mem_whilo   <= ex_whilo;
      mem_valid   <= 1'b1;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end
  end

endmodule
